// File: rtl/wbu_char_enc.sv
// Six-bit code to printable ASCII encoder with a small code FIFO and an
// optional CR/LF newline form. Defining WBU_CHAR_ENC_LINEWRAP_EN adds automatic line wrap.
module wbu_char_enc #(
    parameter int LGFIFO   = 2,
    parameter int LINE_LEN = 72,
    parameter bit OPT_CRLF = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    input  logic [6:0] i_bits,
    output logic       o_busy,
    output logic       o_stb,
    output logic [7:0] o_char,
    input  logic       i_busy
);

    localparam int         DEPTH   = 1 << LGFIFO;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    if (LINE_LEN < 1 || LINE_LEN > 255) begin : g_bad_line_len
        $error("wbu_char_enc: LINE_LEN must be within 1..255");
    end

    typedef enum logic [1:0] {
        ST_DATA,
        ST_CR,
        ST_LF
    } state_t;

    logic [6:0]      fifo_mem [DEPTH];
    logic [LGFIFO:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0] wr_ptr_next, rd_ptr_next;
    logic            fifo_full, fifo_empty;
    logic            fifo_wr, fifo_rd;
    logic [6:0]      head;
    logic            head_nl;
    logic            load;
    logic            data_beat;
    logic            nl_beat;
    logic            wrap_now;
    state_t          state;

    function automatic logic [7:0] encode(input logic [5:0] v);
        logic [7:0] w;
        w = {2'b00, v};
        if (v < 6'd10)
            return w + 8'h30;            // '0'..'9'
        else if (v < 6'd36)
            return w + 8'h37;            // 'A'..'Z'
        else if (v < 6'd62)
            return w + 8'h3D;            // 'a'..'z'
        else if (v == 6'd62)
            return 8'h40;                // '@'
        else
            return 8'h25;                // '%'
    endfunction

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_wr     = i_stb && !fifo_full;
    assign wr_ptr_next = wr_ptr + {{LGFIFO{1'b0}}, fifo_wr};
    assign rd_ptr_next = rd_ptr + {{LGFIFO{1'b0}}, fifo_rd};
    assign head        = fifo_mem[rd_ptr[LGFIFO-1:0]];
    assign head_nl     = head[6];
    assign o_busy      = fifo_full;

    assign load      = !o_stb || !i_busy;
    assign data_beat = load && (state == ST_DATA) && !fifo_empty;
    assign nl_beat   = data_beat && (head_nl || wrap_now);
    // An inserted newline leaves the printable head in place for the next beat.
    assign fifo_rd   = data_beat && !wrap_now;

`ifdef WBU_CHAR_ENC_LINEWRAP_EN
    localparam logic [7:0] COL_LIMIT = 8'(LINE_LEN);

    logic [7:0] column;

    assign wrap_now = (column == COL_LIMIT) && !head_nl;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            column <= 8'd0;
        else if ((load && state == ST_LF) || (nl_beat && !OPT_CRLF))
            column <= 8'd0;
        else if (data_beat && !head_nl && !wrap_now)
            column <= column + 8'd1;
    end
`else
    assign wrap_now = 1'b0;
`endif

    // NOTE: storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (fifo_wr && !i_reset)
            fifo_mem[wr_ptr[LGFIFO-1:0]] <= i_bits;
    end

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_full <= 1'b0;
            o_stb     <= 1'b0;
            o_char    <= 8'h00;
            state     <= ST_DATA;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            fifo_full <= ((wr_ptr_next ^ rd_ptr_next) == {1'b1, {LGFIFO{1'b0}}});

            if (load) begin
                case (state)
                    ST_DATA: begin
                        if (fifo_empty) begin
                            o_stb <= 1'b0;
                        end else if (nl_beat) begin
                            o_stb <= 1'b1;
                            if (OPT_CRLF) begin
                                o_char <= CHAR_CR;
                                state  <= ST_LF;
                            end else begin
                                o_char <= CHAR_LF;
                            end
                        end else begin
                            o_stb  <= 1'b1;
                            o_char <= encode(head[5:0]);
                        end
                    end
                    ST_CR: begin
                        o_stb  <= 1'b1;
                        o_char <= CHAR_CR;
                        state  <= ST_LF;
                    end
                    ST_LF: begin
                        o_stb  <= 1'b1;
                        o_char <= CHAR_LF;
                        state  <= ST_DATA;
                    end
                    default: state <= ST_DATA;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wbu_char_enc.sv
// Directed bench for wbu_char_enc: code map, backpressure, line wrap, CRLF and mid-sequence reset.
// Three instances share stimulus; each test observes one of them through the sel mux.
module tb_wbu_char_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic [6:0] bits = 7'd0;
    logic       busy = 1'b0;

    logic       busy_a, stb_a, busy_w, stb_w, busy_c, stb_c;
    logic [7:0] char_a, char_w, char_c;

    int         sel = 0;
    logic       sel_busy, sel_stb;
    logic [7:0] sel_char;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [7:0] cap_q [$];
    int         cap_t [$];
    logic [6:0] tx_q  [$];
    logic [7:0] exp_q [$];

    logic [6:0] map_codes [9] = '{7'd0, 7'd9, 7'd10, 7'd35, 7'd36, 7'd61, 7'd62, 7'd63, 7'h40};
    logic [7:0] map_chars [9] = '{8'h30, 8'h39, 8'h41, 8'h5A, 8'h61, 8'h7A, 8'h40, 8'h25, 8'h0A};
    logic [6:0] bp_codes  [6] = '{7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25};
    logic       crlf_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       crlf_stb  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] crlf_char [9] = '{8'h00, 8'h0D, 8'h0D, 8'h0D, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00};

    always #5 clk = ~clk;

    wbu_char_enc #(.LGFIFO(2), .LINE_LEN(72), .OPT_CRLF(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_bits(bits),
        .o_busy(busy_a), .o_stb(stb_a), .o_char(char_a), .i_busy(busy)
    );

    wbu_char_enc #(.LGFIFO(2), .LINE_LEN(4), .OPT_CRLF(1'b0)) dut_w (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_bits(bits),
        .o_busy(busy_w), .o_stb(stb_w), .o_char(char_w), .i_busy(busy)
    );

    wbu_char_enc #(.LGFIFO(2), .LINE_LEN(72), .OPT_CRLF(1'b1)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_bits(bits),
        .o_busy(busy_c), .o_stb(stb_c), .o_char(char_c), .i_busy(busy)
    );

    always_comb begin
        sel_busy = busy_a;
        sel_stb  = stb_a;
        sel_char = char_a;
        case (sel)
            1: begin sel_busy = busy_w; sel_stb = stb_w; sel_char = char_w; end
            2: begin sel_busy = busy_c; sel_stb = stb_c; sel_char = char_c; end
            default: ;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A character is consumed at the next rising edge when o_stb is high and i_busy low.
    always @(negedge clk) begin
        if (!rst && sel_stb && !busy) begin
            cap_q.push_back(sel_char);
            cap_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        stb  = 1'b0;
        busy = 1'b0;
        step();
        step();
        rst = 1'b0;
        cap_q.delete();
        cap_t.delete();
    endtask

    // Offers each queued code until the observed instance accepts it; bounded.
    task automatic send_all(input string tag);
        int idx = 0;
        int guard = 0;
        while (idx < tx_q.size() && guard < 200) begin
            stb  = 1'b1;
            bits = tx_q[idx];
            if (!sel_busy)
                idx++;
            step();
            guard++;
        end
        stb = 1'b0;
        check({tag, "_sent"}, idx, tx_q.size());
    endtask

    task automatic compare_cap(input string tag);
        logic [7:0] got;
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 8'hFF;
            check($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
    endtask

    initial begin
        // Reset, with a code offered during the reset cycle that must be ignored.
        sel  = 0;
        rst  = 1'b1;
        stb  = 1'b1;
        bits = 7'd5;
        step();
        step();
        rst = 1'b0;
        stb = 1'b0;
        check("rst_stb", sel_stb, 1'b0);
        check("rst_char", sel_char, 8'h00);
        check("rst_busy", sel_busy, 1'b0);
        step();
        step();
        check("rst_ignored_stb", sel_stb, 1'b0);

        // Code map, two-edge latency, one character per clock.
        do_reset();
        sel = 0;
        for (int i = 0; i < 9; i++) begin
            stb  = 1'b1;
            bits = map_codes[i];
            step();
            if (i == 0) check("map_lat_edge1", sel_stb, 1'b0);
            if (i == 1) begin
                check("map_lat_edge2_stb", sel_stb, 1'b1);
                check("map_lat_edge2_char", sel_char, 8'h30);
            end
        end
        stb = 1'b0;
        repeat (4) step();
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(map_chars[i]);
        compare_cap("map");
        if (cap_t.size() == 9) check("map_rate", cap_t[8] - cap_t[0], 8);

        // Backpressure: stalled for ten edges while six codes are offered.
        do_reset();
        sel = 0;
        begin
            int idx = 0;
            for (int c = 1; c <= 24; c++) begin
                busy = (c <= 10);
                if (idx < 6) begin
                    stb  = 1'b1;
                    bits = bp_codes[idx];
                    if (!sel_busy) idx++;
                end else begin
                    stb = 1'b0;
                end
                step();
                if (c >= 2 && c <= 10) begin
                    check("bp_hold_char", sel_char, 8'h4B);
                    check("bp_hold_stb", sel_stb, 1'b1);
                end
                if (c == 4) check("bp_busy_lo", sel_busy, 1'b0);
                if (c == 5 || c == 10) check("bp_busy_hi", sel_busy, 1'b1);
            end
            check("bp_accepted", idx, 6);
        end
        busy = 1'b0;
        exp_q = '{8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50};
        compare_cap("bp");

        // Line wrap at LINE_LEN=4.
        do_reset();
        sel  = 1;
        tx_q = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6};
        send_all("wrap");
        repeat (6) step();
`ifdef WBU_CHAR_ENC_LINEWRAP_EN
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A, 8'h35, 8'h36};
`else
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
`endif
        compare_cap("wrap");

        // Explicit newline exactly at the wrap column: one newline only.
        do_reset();
        sel  = 1;
        tx_q = '{7'd1, 7'd2, 7'd3, 7'd4, 7'h40, 7'd5};
        send_all("wrapb");
        repeat (6) step();
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A, 8'h35};
        compare_cap("wrapb");

        // CRLF newline with i_busy toggling.
        do_reset();
        sel = 2;
        for (int c = 0; c < 9; c++) begin
            busy = crlf_busy[c];
            stb  = (c == 0);
            bits = 7'h40;
            step();
            check($sformatf("crlf_stb%0d", c), sel_stb, crlf_stb[c]);
            if (crlf_stb[c]) check($sformatf("crlf_char%0d", c), sel_char, crlf_char[c]);
        end
        busy  = 1'b0;
        exp_q = '{8'h0D, 8'h0A};
        compare_cap("crlf");

        // Reset after CR with LF pending and three codes queued.
        do_reset();
        sel  = 2;
        busy = 1'b1;
        stb  = 1'b1;
        bits = 7'h40; step();
        bits = 7'd1;  step();
        bits = 7'd2;  step();
        bits = 7'd3;  step();
        check("mrst_pre_char", sel_char, 8'h0D);
        rst  = 1'b1;
        bits = 7'd7;
        step();
        check("mrst_stb", sel_stb, 1'b0);
        check("mrst_busy", sel_busy, 1'b0);
        check("mrst_char", sel_char, 8'h00);
        rst  = 1'b0;
        busy = 1'b0;
        bits = 7'd12;
        step();
        stb = 1'b0;
        check("mrst_lat_edge1", sel_stb, 1'b0);
        step();
        check("mrst_lat_edge2_stb", sel_stb, 1'b1);
        check("mrst_lat_edge2_char", sel_char, 8'h43);
        step();
        check("mrst_drained", sel_stb, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
